// File: rtl/ratio_sin_scaler.sv
// Handshaked scaler: y = sign(k) * |k| * a / (a+b+c), using an iterative restoring
// divider followed by a single-cycle multiply with round-half-up.
module ratio_sin_scaler #(
    parameter int unsigned DW       = 12,
    parameter int unsigned QW       = 14,
    parameter int unsigned KW       = 13,
    parameter int unsigned OUT_MODE = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic          k_sign,
    input  logic [KW-1:0] k_mag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [KW:0]   y,
    output logic          err
);

    localparam int unsigned SW = DW + 2;
    localparam int unsigned NW = DW + QW + 1;
    localparam int unsigned CW = $clog2(NW);
    localparam int unsigned PW = QW + 1 + KW;
    localparam logic [PW-1:0] HALF = PW'(1) << (QW - 1);

    typedef enum logic [1:0] {IDLE, DIV, MUL, OUT} state_t;

    state_t        state, state_n;
    logic [NW-1:0] dvd, dvd_n;
    logic [SW-1:0] div_s, div_s_n;
    logic          zero_div, zero_div_n;
    logic [SW-1:0] rem, rem_n;
    logic [QW:0]   quo, quo_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          ks, ks_n;
    logic [KW-1:0] km, km_n;
    logic [KW:0]   y_n;
    logic          err_n;
    logic          out_valid_n;

    logic [SW-1:0] sum_c;
    logic [SW:0]   rem_sh;
    logic [SW:0]   diff;
    logic          ge;
    logic [PW-1:0] prod;
    logic [PW-1:0] rounded;
    logic [KW-1:0] m;
    logic [KW:0]   y_enc;

    // Restoring step: bring down the next dividend bit and trial-subtract the divisor.
    assign sum_c   = SW'(a) + SW'(b) + SW'(c);
    assign rem_sh  = {rem, dvd[NW-1]};
    assign ge      = rem_sh >= {1'b0, div_s};
    assign diff    = rem_sh - {1'b0, div_s};
    assign prod    = PW'(quo) * PW'(km);
    assign rounded = prod + HALF;
    assign m       = KW'(rounded >> QW);

    always_comb begin
        y_enc = {1'b0, m};
        if (OUT_MODE == 0) begin
            y_enc = {ks & (m != '0), m};
        end else if (ks) begin
            y_enc = ~{1'b0, m} + (KW + 1)'(1);
        end
    end

    assign in_ready = (state == IDLE) && !rst;

    always_comb begin
        state_n     = state;
        dvd_n       = dvd;
        div_s_n     = div_s;
        zero_div_n  = zero_div;
        rem_n       = rem;
        quo_n       = quo;
        cnt_n       = cnt;
        ks_n        = ks;
        km_n        = km;
        y_n         = y;
        err_n       = err;
        out_valid_n = out_valid;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    dvd_n      = {1'b0, a, QW'(0)};
                    div_s_n    = sum_c;
                    zero_div_n = (sum_c == '0);
                    rem_n      = '0;
                    quo_n      = '0;
                    cnt_n      = CW'(NW - 1);
                    ks_n       = k_sign;
                    km_n       = k_mag;
                    state_n    = DIV;
                end
            end
            DIV: begin
                if (zero_div) begin
                    quo_n   = '0;
                    state_n = MUL;
                end else begin
                    rem_n = ge ? SW'(diff) : SW'(rem_sh);
                    quo_n = {quo[QW-1:0], ge};
                    dvd_n = dvd << 1;
                    if (cnt == '0) begin
                        state_n = MUL;
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end
            end
            MUL: begin
                y_n         = y_enc;
                err_n       = zero_div;
                out_valid_n = 1'b1;
                state_n     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dvd       <= '0;
            div_s     <= '0;
            zero_div  <= 1'b0;
            rem       <= '0;
            quo       <= '0;
            cnt       <= '0;
            ks        <= 1'b0;
            km        <= '0;
            y         <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            dvd       <= dvd_n;
            div_s     <= div_s_n;
            zero_div  <= zero_div_n;
            rem       <= rem_n;
            quo       <= quo_n;
            cnt       <= cnt_n;
            ks        <= ks_n;
            km        <= km_n;
            y         <= y_n;
            err       <= err_n;
            out_valid <= out_valid_n;
        end
    end

endmodule

// File: tb/tb_ratio_sin_scaler.sv
// Directed bench for ratio_sin_scaler: two instances (sign-magnitude and two's
// complement) share the stimulus; expected values are hand-computed.
module tb_ratio_sin_scaler;

    localparam int unsigned DW = 12;
    localparam int unsigned QW = 14;
    localparam int unsigned KW = 13;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] a, b, c;
    logic          k_sign;
    logic [KW-1:0] k_mag;
    logic          out_ready;
    logic          in_ready0, in_ready1;
    logic          out_valid0, out_valid1;
    logic [KW:0]   y0, y1;
    logic          err0, err1;

    int checks;
    int errors;

    ratio_sin_scaler #(.DW(DW), .QW(QW), .KW(KW), .OUT_MODE(0)) u_sm (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .c(c), .k_sign(k_sign), .k_mag(k_mag),
        .out_valid(out_valid0), .out_ready(out_ready), .y(y0), .err(err0)
    );

    ratio_sin_scaler #(.DW(DW), .QW(QW), .KW(KW), .OUT_MODE(1)) u_tc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .c(c), .k_sign(k_sign), .k_mag(k_mag),
        .out_valid(out_valid1), .out_ready(out_ready), .y(y1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operand set: accept, measure latency, check result, optional backpressure.
    task automatic txn(input string tag, input logic [DW-1:0] ta, input logic [DW-1:0] tb,
                       input logic [DW-1:0] tc, input logic tks, input logic [KW-1:0] tkm,
                       input int exp_lat, input logic [KW:0] ey0, input logic [KW:0] ey1,
                       input logic eerr, input int hold);
        int lat;
        out_ready = (hold == 0);
        a = ta; b = tb; c = tc; k_sign = tks; k_mag = tkm;
        in_valid = 1'b1;
        chk({tag, ".in_ready"}, 32'(in_ready0), 32'(1));
        tick();
        in_valid = 1'b0;
        a = '1; b = '1; c = '1; k_sign = ~tks; k_mag = ~tkm;
        lat = 0;
        while (!out_valid0 && lat < 200) begin
            tick();
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".y_sm"}, 32'(y0), 32'(ey0));
        chk({tag, ".y_tc"}, 32'(y1), 32'(ey1));
        chk({tag, ".err_sm"}, 32'(err0), 32'(eerr));
        chk({tag, ".err_tc"}, 32'(err1), 32'(eerr));
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            a = DW'(i + 7); b = DW'(i); c = '0; k_mag = KW'(i + 1);
            tick();
            chk({tag, ".hold_valid"}, 32'(out_valid0), 32'(1));
            chk({tag, ".hold_y"}, 32'(y0), 32'(ey0));
            chk({tag, ".hold_in_ready"}, 32'(in_ready0), 32'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk({tag, ".valid_drop"}, 32'(out_valid0), 32'(0));
        chk({tag, ".idle_ready"}, 32'(in_ready0), 32'(1));
    endtask

    initial begin
        logic ov_seen;
        checks = 0;
        errors = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0; k_sign = 1'b0; k_mag = '0;
        tick();
        tick();
        chk("reset.in_ready", 32'(in_ready0), 32'(0));
        chk("reset.out_valid", 32'(out_valid0), 32'(0));
        chk("reset.y", 32'(y0), 32'(0));
        chk("reset.err", 32'(err0), 32'(0));
        rst = 1'b0;
        #1;
        chk("reset.release_ready", 32'(in_ready0), 32'(1));

        txn("base",     12'd1,   12'd1, 12'd2, 1'b0, 13'd4096, 28, 14'h0400, 14'h0400, 1'b0, 0);
        txn("neg",      12'd1,   12'd1, 12'd2, 1'b1, 13'd4096, 28, 14'h2400, 14'h3C00, 1'b0, 0);
        txn("negzero",  12'd1,   12'd1, 12'd2, 1'b1, 13'd0,    28, 14'h0000, 14'h0000, 1'b0, 0);
        txn("fullq",    12'd100, 12'd0, 12'd0, 1'b0, 13'd8191, 28, 14'd8191, 14'd8191, 1'b0, 0);
        txn("round",    12'd1,   12'd2, 12'd0, 1'b0, 13'd8191, 28, 14'd2730, 14'd2730, 1'b0, 0);
        txn("divzero",  12'd0,   12'd0, 12'd0, 1'b0, 13'd5000, 2,  14'd0,    14'd0,    1'b1, 0);
        txn("errclear", 12'd1,   12'd1, 12'd2, 1'b0, 13'd4096, 28, 14'h0400, 14'h0400, 1'b0, 0);
        txn("backpr",   12'd1,   12'd2, 12'd0, 1'b1, 13'd8191, 28, 14'h2AAA, 14'h3556, 1'b0, 10);

        ov_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            ov_seen = ov_seen | out_valid0;
        end
        chk("backpr.no_ghost", 32'(ov_seen), 32'(0));

        // Abort a computation part-way through the division.
        a = 12'd5; b = 12'd6; c = 12'd7; k_sign = 1'b0; k_mag = 13'd100;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("abort.in_ready", 32'(in_ready0), 32'(1));
        chk("abort.out_valid", 32'(out_valid0), 32'(0));
        ov_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            ov_seen = ov_seen | out_valid0;
        end
        chk("abort.no_result", 32'(ov_seen), 32'(0));

        txn("after_abort", 12'd3, 12'd0, 12'd0, 1'b0, 13'd10, 28, 14'd10, 14'd10, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
